// File: rtl/minmax_stream.sv
// Streaming packet min/max reducer: per-beat NI-lane reduction, cross-beat accumulation,
// one result (value, global index, beat count, overflow) per packet on a valid/ready output.
module minmax_stream #(
  parameter int W        = 10,
  parameter int NI       = 4,
  parameter int MAXBEATS = 256,
  parameter int IDXW     = $clog2(NI*MAXBEATS),
  parameter int BW       = $clog2(MAXBEATS+1),
  parameter int CFG      = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [NI*W-1:0] s_data,
  input  logic            s_last,
  input  logic            us_sel,
  input  logic            min_max_sel,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W-1:0]    m_result,
  output logic [IDXW-1:0] m_index,
  output logic [BW-1:0]   m_beats,
  output logic            m_overflow
);

  localparam int            LW   = (NI > 1) ? $clog2(NI) : 1;
  localparam logic [BW-1:0] BMAX = BW'(MAXBEATS);

  // Strict improvement of cand over inc; equality never wins, so earlier lanes/beats keep ties.
  function automatic logic better(input logic [W-1:0] cand, input logic [W-1:0] inc,
                                  input logic us, input logic mm);
    logic signed [W-1:0] sc, si;
    logic lt, gt;
    sc = cand;
    si = inc;
    lt = us ? (sc < si) : (cand < inc);
    gt = us ? (sc > si) : (cand > inc);
    return mm ? gt : lt;
  endfunction

  logic en, take;
  assign en      = !m_valid || m_ready;
  assign s_ready = en;
  assign take    = s_valid && en;

  logic [BW-1:0] beat_cnt;
  logic          first_beat, us_pkt, mm_pkt, us_cur, mm_cur;
  assign us_cur = first_beat ? us_sel      : us_pkt;
  assign mm_cur = first_beat ? min_max_sel : mm_pkt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt   <= '0;
      first_beat <= 1'b1;
      us_pkt     <= 1'b0;
      mm_pkt     <= 1'b0;
    end else if (take) begin
      if (first_beat) begin
        us_pkt <= us_sel;
        mm_pkt <= min_max_sel;
      end
      first_beat <= s_last;
      if (s_last)                beat_cnt <= '0;
      else if (beat_cnt != BMAX) beat_cnt <= beat_cnt + BW'(1);
    end
  end

  logic [W-1:0]  bw_val;
  logic [LW-1:0] bw_lane;
  always_comb begin
    bw_val  = s_data[W-1:0];
    bw_lane = '0;
    for (int k = 1; k < NI; k++) begin
      if (better(s_data[W*k +: W], bw_val, us_cur, mm_cur)) begin
        bw_val  = s_data[W*k +: W];
        bw_lane = LW'(k);
      end
    end
  end

  // Stage 1: registered beat winner with its packet context
  logic          vld_p1, first_p1, last_p1, ovf_p1, us_p1, mm_p1;
  logic [W-1:0]  val_p1;
  logic [LW-1:0] lane_p1;
  logic [BW-1:0] beat_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     vld_p1 <= 1'b0;
    else if (en) vld_p1 <= take;
  end

  always_ff @(posedge clk) begin
    if (take) begin
      val_p1   <= bw_val;
      lane_p1  <= bw_lane;
      beat_p1  <= beat_cnt;
      first_p1 <= first_beat;
      last_p1  <= s_last;
      ovf_p1   <= (beat_cnt == BMAX);
      us_p1    <= us_cur;
      mm_p1    <= mm_cur;
    end
  end

  logic [IDXW-1:0] idx_new;
  assign idx_new = (CFG == 0) ? IDXW'(beat_p1) * IDXW'(NI) + IDXW'(lane_p1) : '0;

  logic [W-1:0]    acc_val_p2, nxt_val;
  logic [IDXW-1:0] acc_idx_p2, nxt_idx;
  logic [BW-1:0]   acc_beats_p2, nxt_beats;
  logic            acc_ovf_p2, nxt_ovf;

  always_comb begin
    nxt_val   = acc_val_p2;
    nxt_idx   = acc_idx_p2;
    nxt_ovf   = acc_ovf_p2;
    nxt_beats = ovf_p1 ? BMAX : beat_p1 + BW'(1);
    if (first_p1) begin
      nxt_val = val_p1;
      nxt_idx = idx_new;
      nxt_ovf = ovf_p1;
    end else if (ovf_p1) begin
      nxt_ovf = 1'b1;
    end else if (better(val_p1, acc_val_p2, us_p1, mm_p1)) begin
      nxt_val = val_p1;
      nxt_idx = idx_new;
    end
  end

  // Stage 2: packet accumulator
  logic vld_p2, last_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else if (en) begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (en && vld_p1) begin
      acc_val_p2   <= nxt_val;
      acc_idx_p2   <= nxt_idx;
      acc_beats_p2 <= nxt_beats;
      acc_ovf_p2   <= nxt_ovf;
    end
  end

  // Output register: loads the finished packet, holds while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_result   <= '0;
      m_index    <= '0;
      m_beats    <= '0;
      m_overflow <= 1'b0;
    end else if (en) begin
      m_valid <= vld_p2 && last_p2;
      if (vld_p2 && last_p2) begin
        m_result   <= acc_val_p2;
        m_index    <= acc_idx_p2;
        m_beats    <= acc_beats_p2;
        m_overflow <= acc_ovf_p2;
      end
    end
  end

endmodule

// File: tb/tb_minmax_stream.sv
// Directed bench for minmax_stream (W=8, NI=4, MAXBEATS=4) with hand-computed results.
module tb_minmax_stream;

  logic        clk, rst;
  logic        s_valid, s_ready, s_last, us_sel, min_max_sel;
  logic [31:0] s_data;
  logic        m_valid, m_ready, m_overflow;
  logic [7:0]  m_result;
  logic [3:0]  m_index;
  logic [2:0]  m_beats;

  int vectors = 0;
  int miscompares = 0;

  minmax_stream #(.W(8), .NI(4), .MAXBEATS(4), .CFG(0)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .us_sel(us_sel), .min_max_sel(min_max_sel),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
    .m_index(m_index), .m_beats(m_beats), .m_overflow(m_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns 1ns after the accepting edge.
  task automatic beat(input logic [31:0] d, input logic last, input logic us, input logic mm);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last; us_sel = us; min_max_sel = mm;
    while (!s_ready && n < 20) begin
      cycle();
      n++;
    end
    chk("s_ready before accept", s_ready, 1);
    cycle();
    s_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] r, input logic [3:0] i,
                           input logic [2:0] b, input logic o);
    chk({tag, " m_valid"}, m_valid, 1);
    chk({tag, " m_result"}, m_result, r);
    chk({tag, " m_index"}, m_index, i);
    chk({tag, " m_beats"}, m_beats, b);
    chk({tag, " m_overflow"}, m_overflow, o);
  endtask

  task automatic wait_result(input string tag, input logic [7:0] r, input logic [3:0] i,
                             input logic [2:0] b, input logic o);
    int n = 0;
    while (!m_valid && n < 20) begin
      cycle();
      n++;
    end
    check_out(tag, r, i, b, o);
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; m_ready = 1'b1; s_valid = 1'b0; s_data = '0;
    s_last = 1'b0; us_sel = 1'b0; min_max_sel = 1'b0;
    #3;
    chk("reset m_valid", m_valid, 0);
    chk("reset m_result", m_result, 0);
    chk("reset m_index", m_index, 0);
    chk("reset m_beats", m_beats, 0);
    chk("reset m_overflow", m_overflow, 0);
    chk("reset s_ready", s_ready, 1);
    cycle();
    rst = 1'b0;
    cycle();

    // Single beat, unsigned max, tie between lanes 1 and 2; result two edges after acceptance
    beat(32'h01090903, 1'b1, 1'b0, 1'b1);
    chk("t1 valid at accept", m_valid, 0);
    cycle();
    chk("t1 valid after +1", m_valid, 0);
    cycle();
    check_out("t1", 8'h09, 4'd1, 3'd1, 1'b0);
    cycle();
    chk("t1 valid cleared", m_valid, 0);

    // Signed min across three beats, lane tie inside beat 1
    beat(32'h0007FE05, 1'b0, 1'b1, 1'b0);
    beat(32'h01F804F8, 1'b0, 1'b1, 1'b0);
    beat(32'h03030303, 1'b1, 1'b1, 1'b0);
    wait_result("t2", 8'hF8, 4'd4, 3'd3, 1'b0);

    // Backpressure: result A pending while packet B streams in behind it
    m_ready = 1'b0;
    beat(32'h281E140A, 1'b1, 1'b0, 1'b1);
    beat(32'h09050607, 1'b0, 1'b0, 1'b0);
    beat(32'h05010505, 1'b1, 1'b0, 1'b0);
    check_out("t3 A pending", 8'h28, 4'd3, 3'd1, 1'b0);
    chk("t3 s_ready stalled", s_ready, 0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check_out("t3 A held", 8'h28, 4'd3, 3'd1, 1'b0);
      chk("t3 s_ready held", s_ready, 0);
    end
    m_ready = 1'b1;
    cycle();
    chk("t3 A consumed", m_valid, 0);
    wait_result("t3 B", 8'h01, 4'd6, 3'd2, 1'b0);

    // Mode is latched on beat 0; later mode changes are ignored
    beat(32'h03020180, 1'b0, 1'b0, 1'b1);
    beat(32'h00009010, 1'b1, 1'b1, 1'b0);
    wait_result("t4", 8'h90, 4'd5, 3'd2, 1'b0);

    // Overflow: beats 4 and 5 are excluded, count saturates
    beat(32'h00000001, 1'b0, 1'b0, 1'b1);
    beat(32'h00000002, 1'b0, 1'b0, 1'b1);
    beat(32'h00500000, 1'b0, 1'b0, 1'b1);
    beat(32'h00000003, 1'b0, 1'b0, 1'b1);
    beat(32'h000000F0, 1'b0, 1'b0, 1'b1);
    beat(32'hFF000000, 1'b1, 1'b0, 1'b1);
    wait_result("t5", 8'h50, 4'd10, 3'd4, 1'b1);
    beat(32'h07000000, 1'b1, 1'b0, 1'b1);
    wait_result("t5 after ovf", 8'h07, 4'd3, 3'd1, 1'b0);

    // Reset mid-packet discards the partial packet
    beat(32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    beat(32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6 reset m_valid", m_valid, 0);
    chk("t6 reset m_result", m_result, 0);
    cycle();
    rst = 1'b0;
    cycle();
    beat(32'h00000002, 1'b1, 1'b0, 1'b1);
    wait_result("t6", 8'h02, 4'd0, 3'd1, 1'b0);

    // Back-to-back single-beat packets, signed max, results on consecutive cycles
    beat(32'h0000807F, 1'b1, 1'b1, 1'b1);
    beat(32'h05FF8001, 1'b1, 1'b1, 1'b1);
    cycle();
    check_out("t7 P1", 8'h7F, 4'd0, 3'd1, 1'b0);
    cycle();
    check_out("t7 P2", 8'h05, 4'd3, 3'd1, 1'b0);
    cycle();
    chk("t7 idle", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
